// File: rtl/wgt_buf_pkg.sv
// rtl/wgt_buf_pkg.sv - shared bank-state encoding and default sizes for the weight ping-pong buffer
package wgt_buf_pkg;

    localparam int DEF_DATA_WID = 16;
    localparam int DEF_LANES    = 8;
    localparam int DEF_DEPTH    = 32;

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'b00,
        BANK_FILL  = 2'b01,
        BANK_READY = 2'b10
    } bank_state_e;

endpackage

// File: rtl/wgt_bank.sv
// rtl/wgt_bank.sv - one DEPTH x LANES weight bank with lane-masked row write and registered row read
module wgt_bank
    import wgt_buf_pkg::*;
#(
    parameter  int DATA_WID = DEF_DATA_WID,
    parameter  int LANES    = DEF_LANES,
    parameter  int DEPTH    = DEF_DEPTH,
    localparam int AW       = $clog2(DEPTH),
    localparam int ROW_W    = LANES * DATA_WID
) (
    input  logic             clock,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [ROW_W-1:0] i_wr_data,
    input  logic [LANES-1:0] i_wr_lane_mask,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [ROW_W-1:0] o_rd_data
);

    // Storage is never reset: a row is only readable once its bank is READY.
    logic [ROW_W-1:0] r_mem [DEPTH];
    logic [ROW_W-1:0] r_rd_data;
    logic [ROW_W-1:0] w_wr_row;
    logic             w_wr_in_range;
    logic             w_rd_in_range;

    always_comb begin
        w_wr_row = '0;
        for (int k = 0; k < LANES; k++) begin
            if (i_wr_lane_mask[k]) begin
                w_wr_row[k*DATA_WID +: DATA_WID] = i_wr_data[k*DATA_WID +: DATA_WID];
            end
        end
    end

    // With a power-of-two depth every address is in range, so skip the compare.
    if (DEPTH == (1 << AW)) begin : g_pow2
        assign w_wr_in_range = 1'b1;
        assign w_rd_in_range = 1'b1;
    end else begin : g_npow2
        localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];
        assign w_wr_in_range = ({1'b0, i_wr_addr} < DEPTH_V);
        assign w_rd_in_range = ({1'b0, i_rd_addr} < DEPTH_V);
    end

    always_ff @(posedge clock) begin
        if (i_wr_en && w_wr_in_range) begin
            r_mem[i_wr_addr] <= w_wr_row;
        end
        if (i_rd_en) begin
            r_rd_data <= w_rd_in_range ? r_mem[i_rd_addr] : '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/wgt_pingpong_buf.sv
// rtl/wgt_pingpong_buf.sv - two-bank weight buffer: one bank fills while the other is read
module wgt_pingpong_buf
    import wgt_buf_pkg::*;
#(
    parameter  int DATA_WID = DEF_DATA_WID,
    parameter  int LANES    = DEF_LANES,
    parameter  int DEPTH    = DEF_DEPTH,
    localparam int AW       = $clog2(DEPTH),
    localparam int NW       = $clog2(LANES + 1),
    localparam int ROW_W    = LANES * DATA_WID
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [ROW_W-1:0] wr_data,
    input  logic [NW-1:0]    wr_valid_num,
    input  logic             load_done,
    output logic             wr_ready,
    output logic             load_err,
    output logic             rd_ready,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [ROW_W-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_release
);

    bank_state_e      r_bank_st [2];
    bank_state_e      w_bank_st_nxt [2];
    logic             r_wr_ptr, w_wr_ptr_nxt;
    logic             r_rd_ptr, w_rd_ptr_nxt;
    logic             r_load_err, w_load_err_nxt;
    logic             r_rd_valid;
    logic             r_rd_sel;
    logic             w_wr_accept;
    logic             w_rd_accept;
    logic [LANES-1:0] w_lane_mask;
    logic [ROW_W-1:0] w_bank_rd_data [2];

    assign wr_ready = (r_bank_st[r_wr_ptr] == BANK_EMPTY);
    assign rd_ready = (r_bank_st[r_rd_ptr] == BANK_READY);

    // load_done takes priority over a simultaneous load_start; release works on the other bank.
    always_comb begin
        w_bank_st_nxt  = r_bank_st;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_load_err_nxt = 1'b0;
        if (load_done) begin
            if (r_bank_st[r_wr_ptr] == BANK_FILL) begin
                w_bank_st_nxt[r_wr_ptr] = BANK_READY;
                w_wr_ptr_nxt            = ~r_wr_ptr;
            end else begin
                w_load_err_nxt = 1'b1;
            end
        end else if (load_start) begin
            if (r_bank_st[r_wr_ptr] == BANK_EMPTY) begin
                w_bank_st_nxt[r_wr_ptr] = BANK_FILL;
            end else begin
                w_load_err_nxt = 1'b1;
            end
        end
        if (rd_release && rd_ready) begin
            w_bank_st_nxt[r_rd_ptr] = BANK_EMPTY;
            w_rd_ptr_nxt            = ~r_rd_ptr;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_st[0] <= BANK_EMPTY;
            r_bank_st[1] <= BANK_EMPTY;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_load_err   <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_sel     <= 1'b0;
        end else begin
            r_bank_st  <= w_bank_st_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_load_err <= w_load_err_nxt;
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_sel <= r_rd_ptr;
            end
        end
    end

    // Lanes at or above the valid count are written as zero; a zero count skips the write.
    always_comb begin
        w_lane_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            w_lane_mask[k] = (NW'(k) < wr_valid_num);
        end
    end

    assign w_wr_accept = wr_en && (r_bank_st[r_wr_ptr] == BANK_FILL) && (wr_valid_num != '0);
    assign w_rd_accept = rd_en && rd_ready;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        wgt_bank #(
            .DATA_WID (DATA_WID),
            .LANES    (LANES),
            .DEPTH    (DEPTH)
        ) u_bank (
            .clock          (clock),
            .i_wr_en        (w_wr_accept && (r_wr_ptr == 1'(b))),
            .i_wr_addr      (wr_addr),
            .i_wr_data      (wr_data),
            .i_wr_lane_mask (w_lane_mask),
            .i_rd_en        (w_rd_accept && (r_rd_ptr == 1'(b))),
            .i_rd_addr      (rd_addr),
            .o_rd_data      (w_bank_rd_data[b])
        );
    end

    assign rd_data  = r_rd_valid ? w_bank_rd_data[r_rd_sel] : '0;
    assign rd_valid = r_rd_valid;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_wgt_pingpong_buf.sv
// tb/tb_wgt_pingpong_buf.sv - self-checking bench: vector table, corner sequences, random run vs reference model
module tb_wgt_pingpong_buf;

    localparam int DW = 16;
    localparam int LN = 8;
    localparam int DP = 32;
    localparam int AW = 5;
    localparam int NW = 4;
    localparam int RW = DW * LN;
    localparam int S_EMPTY = 0;
    localparam int S_FILL  = 1;
    localparam int S_READY = 2;
    localparam logic [RW-1:0] ZR = '0;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          load_start, wr_en, load_done, rd_en, rd_release;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [RW-1:0] wr_data;
    logic [NW-1:0] wr_valid_num;
    logic          wr_ready, load_err, rd_ready, rd_valid;
    logic [RW-1:0] rd_data;

    always #5 clock = ~clock;

    wgt_pingpong_buf dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_valid_num (wr_valid_num),
        .load_done    (load_done),
        .wr_ready     (wr_ready),
        .load_err     (load_err),
        .rd_ready     (rd_ready),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_release   (rd_release)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: per-bank state, two pointers, lane-level row contents.
    int            m_st [2];
    int            m_wp, m_rp;
    logic [DW-1:0] m_mem [2][DP][LN];
    bit            m_known [2][DP];
    logic          e_val, e_err, e_known;
    logic [RW-1:0] e_data;

    typedef struct {
        logic          ls, we, ld, re, rr;
        logic [AW-1:0] wa, ra;
        logic [RW-1:0] wd;
        logic [NW-1:0] wn;
        logic          wrdy, rrdy, val, err;
        logic [RW-1:0] data;
    } vec_t;
    vec_t vecs [$];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_row(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] pat(input int base, input int n);
        logic [RW-1:0] r;
        r = '0;
        for (int k = 0; k < LN; k++) begin
            if (k < n) r[k*DW +: DW] = DW'(base + k);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_st[0] = S_EMPTY;
        m_st[1] = S_EMPTY;
        m_wp = 0;
        m_rp = 0;
        e_val = 1'b0;
        e_err = 1'b0;
        e_data = '0;
        e_known = 1'b1;
    endtask

    task automatic model_edge();
        int  n;
        bit  was_ready;
        e_val = 1'b0;
        e_err = 1'b0;
        e_data = '0;
        e_known = 1'b1;
        if (!rst_n) begin
            model_reset();
            return;
        end
        was_ready = (m_st[m_rp] == S_READY);
        if (rd_en && was_ready) begin
            e_val = 1'b1;
            if (int'(rd_addr) < DP) begin
                e_known = m_known[m_rp][rd_addr];
                for (int k = 0; k < LN; k++) e_data[k*DW +: DW] = m_mem[m_rp][rd_addr][k];
            end
        end
        if (wr_en && m_st[m_wp] == S_FILL && int'(wr_addr) < DP && wr_valid_num != 0) begin
            n = (int'(wr_valid_num) < LN) ? int'(wr_valid_num) : LN;
            for (int k = 0; k < LN; k++)
                m_mem[m_wp][wr_addr][k] = (k < n) ? wr_data[k*DW +: DW] : '0;
            m_known[m_wp][wr_addr] = 1'b1;
        end
        if (load_done) begin
            if (m_st[m_wp] == S_FILL) begin
                m_st[m_wp] = S_READY;
                m_wp = 1 - m_wp;
            end else begin
                e_err = 1'b1;
            end
        end else if (load_start) begin
            if (m_st[m_wp] == S_EMPTY) m_st[m_wp] = S_FILL;
            else e_err = 1'b1;
        end
        if (rd_release && was_ready) begin
            m_st[m_rp] = S_EMPTY;
            m_rp = 1 - m_rp;
        end
    endtask

    task automatic idle();
        load_start = 0; wr_en = 0; load_done = 0; rd_en = 0; rd_release = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_valid_num = '0;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        cyc++;
        chk1("wr_ready", wr_ready, m_st[m_wp] == S_EMPTY);
        chk1("rd_ready", rd_ready, m_st[m_rp] == S_READY);
        chk1("rd_valid", rd_valid, e_val);
        chk1("load_err", load_err, e_err);
        if (e_known) chk_row("rd_data", rd_data, e_data);
    endtask

    task automatic add(input int ls, input int we, input int wa, input logic [RW-1:0] wd, input int wn,
                       input int ld, input int re, input int ra, input int rr,
                       input int wrdy, input int rrdy, input int val, input int err, input logic [RW-1:0] data);
        vec_t v;
        v.ls = 1'(ls); v.we = 1'(we); v.wa = AW'(wa); v.wd = wd; v.wn = NW'(wn);
        v.ld = 1'(ld); v.re = 1'(re); v.ra = AW'(ra); v.rr = 1'(rr);
        v.wrdy = 1'(wrdy); v.rrdy = 1'(rrdy); v.val = 1'(val); v.err = 1'(err); v.data = data;
        vecs.push_back(v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int burst;
        //   ls we wa wd              wn ld re ra rr  wrdy rrdy val err data
        add(1, 0, 0, ZR,             0, 0, 0, 0, 0,  0, 0, 0, 0, ZR);
        for (int r = 0; r < 4; r++)
            add(0, 1, r, pat(16*r+1, 8), 8, 0, 0, 0, 0,  0, 0, 0, 0, ZR);
        add(0, 1, 4, pat(1, 8),      3, 0, 0, 0, 0,  0, 0, 0, 0, ZR);
        add(0, 1, 5, pat('h50, 8),   8, 0, 0, 0, 0,  0, 0, 0, 0, ZR);
        add(0, 1, 5, pat('h70, 8),   0, 0, 0, 0, 0,  0, 0, 0, 0, ZR);
        add(0, 1, 6, pat('h60, 8),  12, 0, 0, 0, 0,  0, 0, 0, 0, ZR);
        add(0, 0, 0, ZR,             0, 1, 0, 0, 0,  1, 1, 0, 0, ZR);
        add(0, 0, 0, ZR,             0, 0, 1, 2, 0,  1, 1, 1, 0, pat(33, 8));
        add(0, 0, 0, ZR,             0, 0, 1, 4, 0,  1, 1, 1, 0, pat(1, 3));
        add(0, 0, 0, ZR,             0, 0, 1, 5, 0,  1, 1, 1, 0, pat('h50, 8));
        add(0, 0, 0, ZR,             0, 0, 1, 6, 0,  1, 1, 1, 0, pat('h60, 8));
        add(0, 0, 0, ZR,             0, 0, 0, 0, 0,  1, 1, 0, 0, ZR);
        add(0, 0, 0, ZR,             0, 1, 0, 0, 0,  1, 1, 0, 1, ZR);
        add(0, 0, 0, ZR,             0, 0, 0, 0, 0,  1, 1, 0, 0, ZR);
        add(1, 0, 0, ZR,             0, 0, 0, 0, 0,  0, 1, 0, 0, ZR);
        add(0, 1, 0, pat('h200, 8),  8, 0, 0, 0, 0,  0, 1, 0, 0, ZR);
        add(0, 0, 0, ZR,             0, 1, 0, 0, 0,  0, 1, 0, 0, ZR);
        add(1, 0, 0, ZR,             0, 0, 0, 0, 0,  0, 1, 0, 1, ZR);
        add(0, 0, 0, ZR,             0, 0, 0, 0, 0,  0, 1, 0, 0, ZR);
        add(0, 1, 0, pat('h999, 8),  8, 0, 0, 0, 0,  0, 1, 0, 0, ZR);
        add(0, 0, 0, ZR,             0, 0, 1, 0, 0,  0, 1, 1, 0, pat(1, 8));
        add(0, 0, 0, ZR,             0, 0, 0, 0, 1,  1, 1, 0, 0, ZR);
        add(0, 0, 0, ZR,             0, 0, 1, 0, 0,  1, 1, 1, 0, pat('h200, 8));
        add(1, 0, 0, ZR,             0, 0, 0, 0, 0,  0, 1, 0, 0, ZR);
        add(0, 1, 0, pat('h300, 8),  8, 0, 0, 0, 0,  0, 1, 0, 0, ZR);
        add(0, 0, 0, ZR,             0, 1, 1, 0, 1,  1, 1, 1, 0, pat('h200, 8));
        add(0, 0, 0, ZR,             0, 0, 1, 0, 0,  1, 1, 1, 0, pat('h300, 8));
        add(1, 0, 0, ZR,             0, 1, 0, 0, 0,  1, 1, 0, 1, ZR);
        add(0, 0, 0, ZR,             0, 0, 0, 0, 0,  1, 1, 0, 0, ZR);

        idle();
        rst_n = 1'b0;
        model_reset();
        @(negedge clock);
        chk1("reset_wr_ready", wr_ready, 1'b1);
        chk1("reset_rd_ready", rd_ready, 1'b0);
        chk1("reset_rd_valid", rd_valid, 1'b0);
        chk1("reset_load_err", load_err, 1'b0);
        chk_row("reset_rd_data", rd_data, ZR);
        cycle();
        rst_n = 1'b1;
        cycle();

        foreach (vecs[i]) begin
            load_start = vecs[i].ls; wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            wr_valid_num = vecs[i].wn; load_done = vecs[i].ld; rd_en = vecs[i].re;
            rd_addr = vecs[i].ra; rd_release = vecs[i].rr;
            cycle();
            chk1($sformatf("tbl%0d_wr_ready", i), wr_ready, vecs[i].wrdy);
            chk1($sformatf("tbl%0d_rd_ready", i), rd_ready, vecs[i].rrdy);
            chk1($sformatf("tbl%0d_rd_valid", i), rd_valid, vecs[i].val);
            chk1($sformatf("tbl%0d_load_err", i), load_err, vecs[i].err);
            chk_row($sformatf("tbl%0d_rd_data", i), rd_data, vecs[i].data);
        end

        // Release bank0, then a release with nothing ready must be ignored.
        idle(); rd_release = 1; cycle();
        chk1("release_rd_ready", rd_ready, 1'b0);
        cycle();
        // Fill bank1 completely, then stream all of it while bank0 fills.
        idle(); load_start = 1; cycle();
        for (int r = 0; r < DP; r++) begin
            idle(); wr_en = 1; wr_addr = AW'(r); wr_valid_num = NW'(LN);
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        idle(); load_done = 1; cycle();
        idle(); load_start = 1; cycle();
        burst = 0;
        for (int r = 0; r < DP; r++) begin
            idle(); wr_en = 1; wr_addr = AW'(r); wr_valid_num = NW'(LN);
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            rd_en = 1; rd_addr = AW'(r);
            cycle();
            if (rd_valid === 1'b1) burst++;
        end
        chk_int("burst_valid_count", burst, DP);

        // Reset mid-fill with a read in flight.
        idle(); rd_en = 1; rd_addr = 5'd7; wr_en = 1; wr_addr = 5'd1; wr_valid_num = 4'd8; cycle();
        chk1("preflight_rd_valid", rd_valid, 1'b1);
        idle(); rst_n = 1'b0;
        #1;
        chk1("midreset_wr_ready", wr_ready, 1'b1);
        chk1("midreset_rd_ready", rd_ready, 1'b0);
        chk1("midreset_rd_valid", rd_valid, 1'b0);
        cycle();
        rst_n = 1'b1;
        rd_en = 1; rd_addr = 5'd3; cycle();
        chk1("postreset_read_valid", rd_valid, 1'b0);
        chk_row("postreset_read_data", rd_data, ZR);

        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom_range(0, 399) != 0);
            load_start   = ($urandom_range(0, 5) == 0);
            load_done    = ($urandom_range(0, 15) == 0);
            rd_release   = ($urandom_range(0, 15) == 0);
            wr_en        = 1'($urandom_range(0, 1));
            rd_en        = 1'($urandom_range(0, 1));
            wr_addr      = AW'($urandom_range(0, DP-1));
            rd_addr      = AW'($urandom_range(0, DP-1));
            wr_valid_num = NW'($urandom_range(0, 15));
            wr_data      = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wgt_pingpong_buf.md
WGT_PINGPONG_BUF -- requirements
Module: wgt_pingpong_buf

Interface
REQ-001 The block SHALL have parameter DATA_WID, default 16, meaning width of one weight element.
REQ-002 The block SHALL have parameter LANES, default 8, meaning weight elements per row.
REQ-003 The block SHALL have parameter DEPTH, default 32, meaning rows per bank; AW = clog2(DEPTH), NW = clog2(LANES+1).
REQ-004 The ports SHALL be as follows; reset is rst_n, asynchronous, active-low, and the clock is clock.
- clock  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  pulse; begin filling the current write bank.
- wr_en  in  1  row write strobe.
- wr_addr  in  AW  row index.
- wr_data  in  LANES*DATA_WID  row data; lane k at bits [k*DATA_WID +: DATA_WID].
- wr_valid_num  in  NW  number of real lanes in the row.
- load_done  in  1  pulse; fill complete.
- wr_ready  out  1  write bank EMPTY; load_start will be accepted.
- load_err  out  1  one-cycle pulse; load_start or load_done was rejected.
- rd_ready  out  1  read bank READY.
- rd_en  in  1  fetch request.
- rd_addr  in  AW  row to fetch.
- rd_data  out  LANES*DATA_WID  fetched row.
- rd_valid  out  1  rd_data valid.
- rd_release  in  1  pulse; consumer is finished with the read bank.

Function
REQ-005 The block SHALL hold two banks; each bank SHALL be in state EMPTY, FILL or READY, and the block SHALL hold pointers wr_ptr and rd_ptr, each 1 bit.
REQ-006 On load_start with bank[wr_ptr]==EMPTY, the block SHALL set that bank to FILL on the next edge.
REQ-007 On load_start with bank[wr_ptr] not EMPTY, the block SHALL ignore the request and pulse load_err for one cycle.
REQ-008 On wr_en while bank[wr_ptr]==FILL and wr_addr<DEPTH, the block SHALL write lanes 0..n-1 from wr_data and zero lanes n..LANES-1, where n = min(wr_valid_num, LANES).
REQ-009 When wr_valid_num==0, the block SHALL leave the row unchanged.
REQ-010 The block SHALL ignore wr_en outside FILL and SHALL ignore wr_en with wr_addr>=DEPTH; neither case SHALL raise an error.
REQ-011 On load_done with bank[wr_ptr]==FILL, the block SHALL set that bank to READY and toggle wr_ptr.
REQ-012 On load_done in any other state, the block SHALL pulse load_err and change no state.
REQ-013 load_start and load_done asserted in the same cycle SHALL be treated as load_done only.
REQ-014 The block SHALL drive wr_ready = (bank[wr_ptr]==EMPTY) and rd_ready = (bank[rd_ptr]==READY), both combinational from the registered state.
REQ-015 On rd_en with rd_ready=1, rd_data SHALL present row rd_addr of bank[rd_ptr] one cycle later with rd_valid=1.
REQ-016 When rd_addr>=DEPTH, rd_data SHALL be 0 with rd_valid=1.
REQ-017 In any cycle following no accepted rd_en, rd_valid SHALL be 0 and rd_data SHALL be 0.
REQ-018 Back-to-back rd_en SHALL give one row per cycle at full throughput.
REQ-019 On rd_release with rd_ready=1, the block SHALL set bank[rd_ptr] to EMPTY and toggle rd_ptr on that edge.
REQ-020 A rd_en in the same cycle as rd_release SHALL still return data from the released bank.
REQ-021 A rd_release with rd_ready=0 SHALL be ignored.
REQ-022 load_done and rd_release in the same cycle SHALL both take effect; they always address different banks.
REQ-023 Filling one bank SHALL NOT disturb reads of the other bank (overlap of fill and compute).

Reset
REQ-024 While rst_n=0, both banks SHALL be EMPTY, wr_ptr=rd_ptr=0, rd_data=0, rd_valid=0 and load_err=0, giving wr_ready=1 and rd_ready=0.
REQ-025 Assertion of rst_n mid-fill or mid-read SHALL abandon all bank contents and states.
REQ-026 Row storage SHALL NOT require reset, since no row is readable before its bank reaches READY.

Structure
REQ-027 A shared package wgt_buf_pkg SHALL hold the bank-state encoding (EMPTY=2'b00, FILL=2'b01, READY=2'b10) and the default parameter values.
REQ-028 A sub-module wgt_bank (DEPTH x LANES storage, lane-masked write, registered read) SHALL be instantiated twice.
REQ-029 Pointer and bank-state control SHALL reside in the top level.

Verification
REQ-030 Reset, then load_start, write rows 0..3 with wr_valid_num=8, then load_done -> rd_ready=1 and wr_ready=1; rd_en with rd_addr=2 returns row 2 next cycle with rd_valid=1.
REQ-031 Write a row with wr_valid_num=3 and wr_data lanes 0x0001..0x0008 -> read returns 0x0001,0x0002,0x0003 with lanes 3..7 = 0.
REQ-032 Fill bank0 and bank1 without any rd_release, then load_start -> load_err pulses for one cycle and wr_ready stays 0; rd_release -> wr_ready=1.
REQ-033 While bank1 fills, read rows 0..31 of bank0 back-to-back -> 32 consecutive rd_valid cycles with no corruption.
REQ-034 rd_release and load_done in the same cycle -> rd_ptr and wr_ptr both toggle, and rd_ready stays 1 with the new bank.
REQ-035 Assert rst_n low mid-fill -> wr_ready=1, rd_ready=0 and rd_valid=0, and a subsequent read before any new load returns nothing.
